// File: rtl/feed_sample_buffer.sv
// Word FIFO feeding a MSB-first sample unpacker for the real-time GPS data feed.
// Supports continuous/single-step advance, halt, occupancy readout and sticky error flags.
module feed_sample_buffer #(
    parameter int WORD_WIDTH   = 16,
    parameter int SAMPLE_WIDTH = 2,
    parameter int ADDR_WIDTH   = 9
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    word_valid,
    input  logic [WORD_WIDTH-1:0]   word_in,
    output logic                    full,
    output logic [ADDR_WIDTH:0]     words_available,
    input  logic                    step_mode,
    input  logic                    sample_en,
    input  logic                    step,
    input  logic                    halt,
    output logic                    sample_valid,
    output logic [SAMPLE_WIDTH-1:0] sample_out,
    output logic                    have_data,
    input  logic                    clear_flags,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int SPW   = WORD_WIDTH / SAMPLE_WIDTH;
    localparam int IDXW  = (SPW > 1) ? $clog2(SPW) : 1;

    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = 1;
    localparam logic [IDXW-1:0]       IDX_ONE  = 1;
    localparam logic [IDXW-1:0]       IDX_LAST = IDXW'(SPW - 1);

    logic [WORD_WIDTH-1:0]   r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0]   r_wr_ptr;
    logic [ADDR_WIDTH-1:0]   r_rd_ptr;
    logic [ADDR_WIDTH:0]     r_count;
    logic [WORD_WIDTH-1:0]   r_holder;
    logic                    r_loaded;
    logic [IDXW-1:0]         r_idx;
    logic                    r_step_q;
    logic                    r_sample_valid;
    logic [SAMPLE_WIDTH-1:0] r_sample_out;
    logic                    r_overflow;
    logic                    r_underflow;

    logic w_full;
    logic w_fifo_ne;
    logic w_adv;
    logic w_last;
    logic w_wr;
    logic w_load;

    // Count never exceeds DEPTH, so its MSB alone marks a full FIFO.
    assign w_full    = r_count[ADDR_WIDTH];
    assign w_fifo_ne = |r_count;
    assign w_adv     = ~halt & (step_mode ? (step & ~r_step_q) : sample_en);
    assign w_last    = (r_idx == IDX_LAST);
    assign w_wr      = word_valid & ~w_full;
    // Reload when empty, or on the final slice so output stays gapless.
    assign w_load    = w_fifo_ne & (~r_loaded | (w_adv & w_last));

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= word_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_holder       <= '0;
            r_loaded       <= 1'b0;
            r_idx          <= '0;
            r_step_q       <= 1'b0;
            r_sample_valid <= 1'b0;
            r_sample_out   <= '0;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            r_step_q       <= step;
            r_sample_valid <= 1'b0;

            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end

            case ({w_wr, w_load})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase

            if (w_adv && r_loaded) begin
                r_sample_out   <= r_holder[WORD_WIDTH-1 -: SAMPLE_WIDTH];
                r_sample_valid <= 1'b1;
                r_holder       <= r_holder << SAMPLE_WIDTH;
                if (w_last) begin
                    r_idx    <= '0;
                    r_loaded <= 1'b0;
                end else begin
                    r_idx <= r_idx + IDX_ONE;
                end
            end

            // A load overrides the shift/empty above on the same edge.
            if (w_load) begin
                r_holder <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                r_loaded <= 1'b1;
                r_idx    <= '0;
            end

            if (clear_flags) begin
                r_overflow <= 1'b0;
            end else if (word_valid && w_full) begin
                r_overflow <= 1'b1;
            end

            if (clear_flags) begin
                r_underflow <= 1'b0;
            end else if (w_adv && !r_loaded) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign full            = w_full;
    assign words_available = r_count;
    assign have_data       = r_loaded | w_fifo_ne;
    assign sample_valid    = r_sample_valid;
    assign sample_out      = r_sample_out;
    assign overflow        = r_overflow;
    assign underflow       = r_underflow;

endmodule

// File: tb/tb_feed_sample_buffer.sv
// Directed bench for feed_sample_buffer: unpacking order, full/overflow,
// gapless streaming, single-step/halt, async reset and flag/count corner cases.
module tb_feed_sample_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        word_valid = 1'b0;
    logic [15:0] word_in = 16'h0;
    logic        full;
    logic [9:0]  words_available;
    logic        step_mode = 1'b0;
    logic        sample_en = 1'b0;
    logic        step = 1'b0;
    logic        halt = 1'b0;
    logic        sample_valid;
    logic [1:0]  sample_out;
    logic        have_data;
    logic        clear_flags = 1'b0;
    logic        overflow;
    logic        underflow;

    int n_vec = 0;
    int n_bad = 0;

    // 16'hA5C3 sliced MSB-first.
    logic [1:0] exp1 [8] = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd3, 2'd0, 2'd0, 2'd3};
    // 16'h0123, 16'hFEDC, 16'h8421 sliced MSB-first.
    logic [1:0] exp3 [24] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3,
                              2'd3, 2'd3, 2'd3, 2'd2, 2'd3, 2'd1, 2'd3, 2'd0,
                              2'd2, 2'd0, 2'd1, 2'd0, 2'd0, 2'd2, 2'd0, 2'd1};
    logic [15:0] words3 [3] = '{16'h0123, 16'hFEDC, 16'h8421};

    feed_sample_buffer #(
        .WORD_WIDTH  (16),
        .SAMPLE_WIDTH(2),
        .ADDR_WIDTH  (9)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .word_valid     (word_valid),
        .word_in        (word_in),
        .full           (full),
        .words_available(words_available),
        .step_mode      (step_mode),
        .sample_en      (sample_en),
        .step           (step),
        .halt           (halt),
        .sample_valid   (sample_valid),
        .sample_out     (sample_out),
        .have_data      (have_data),
        .clear_flags    (clear_flags),
        .overflow       (overflow),
        .underflow      (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pat(input int k);
        return 16'(k * 40503 + 241);
    endfunction

    function automatic logic [31:0] all_outs();
        return 32'({full, words_available, sample_valid, sample_out, have_data, overflow, underflow});
    endfunction

    initial begin
        int pulses;
        int gaps;
        logic [15:0] acc;

        // Reset state
        #12;
        check("reset_outputs", all_outs(), 32'h0);
        tick();
        reset = 1'b0;
        tick();
        check("idle_after_reset", all_outs(), 32'h0);

        // 1: single word, continuous advance
        word_valid = 1'b1; word_in = 16'hA5C3; tick(); word_valid = 1'b0;
        check("t1_count_after_write", 32'(words_available), 32'd1);
        tick();
        check("t1_count_after_load", 32'(words_available), 32'd0);
        check("t1_have_data", 32'(have_data), 32'd1);
        sample_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            $display("t1 slice %0d valid=%0d sample=%0d", i, sample_valid, sample_out);
            check("t1_valid", 32'(sample_valid), 32'd1);
            check("t1_sample", 32'(sample_out), 32'(exp1[i]));
        end
        tick();
        sample_en = 1'b0;
        check("t1_no_valid_when_empty", 32'(sample_valid), 32'd0);
        check("t1_underflow", 32'(underflow), 32'd1);
        check("t1_sample_held", 32'(sample_out), 32'd3);

        // 3: three-word gapless stream
        clear_flags = 1'b1; tick(); clear_flags = 1'b0;
        check("t3_underflow_cleared", 32'(underflow), 32'd0);
        word_valid = 1'b1;
        for (int w = 0; w < 3; w++) begin
            word_in = words3[w];
            tick();
        end
        word_valid = 1'b0;
        check("t3_count_before_stream", 32'(words_available), 32'd2);
        sample_en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            tick();
            $display("t3 slice %0d valid=%0d sample=%0d avail=%0d", i, sample_valid, sample_out, words_available);
            check("t3_valid", 32'(sample_valid), 32'd1);
            check("t3_sample", 32'(sample_out), 32'(exp3[i]));
            if (i == 7) check("t3_count_after_w0", 32'(words_available), 32'd1);
        end
        sample_en = 1'b0;
        check("t3_count_end", 32'(words_available), 32'd0);
        check("t3_have_data_end", 32'(have_data), 32'd0);
        check("t3_no_underflow", 32'(underflow), 32'd0);

        // 4: single-step and halt, word 16'h6C00 -> 1,2,3,0,...
        step_mode = 1'b1;
        word_valid = 1'b1; word_in = 16'h6C00; tick(); word_valid = 1'b0;
        tick();
        pulses = 0;
        step = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (sample_valid) pulses++;
        end
        check("t4_one_pulse", 32'(pulses), 32'd1);
        check("t4_step_sample", 32'(sample_out), 32'd1);
        step = 1'b0; tick();
        halt = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step = (i % 2 == 0);
            tick();
            if (sample_valid) pulses++;
        end
        check("t4_halt_no_pulse", 32'(pulses), 32'd0);
        step = 1'b0; halt = 1'b0; tick();
        step = 1'b1; tick();
        $display("t4 step after halt valid=%0d sample=%0d", sample_valid, sample_out);
        check("t4_resume_valid", 32'(sample_valid), 32'd1);
        check("t4_resume_index_kept", 32'(sample_out), 32'd2);
        step = 1'b0; tick();
        step = 1'b1; tick();
        step = 1'b0;
        check("t4_third_slice", 32'(sample_out), 32'd3);

        // 5: async reset at slice index 3
        #2;
        reset = 1'b1;
        #1;
        check("t5_async_reset_outputs", all_outs(), 32'h0);
        tick();
        reset = 1'b0;
        step_mode = 1'b0;
        word_valid = 1'b1; word_in = 16'hC000; tick(); word_valid = 1'b0;
        check("t5_count_fresh", 32'(words_available), 32'd1);
        tick();
        sample_en = 1'b1; tick(); sample_en = 1'b0;
        $display("t5 first sample after reset valid=%0d sample=%0d", sample_valid, sample_out);
        check("t5_slice0_first", 32'({sample_valid, sample_out}), 32'h7);

        // 2: fill to full, overflow, then drain and verify data
        reset = 1'b1; tick(); reset = 1'b0;
        word_valid = 1'b1;
        for (int k = 0; k < 513; k++) begin
            word_in = pat(k);
            tick();
            if (k == 511) check("t2_count_511", 32'({full, words_available}), 32'd511);
        end
        check("t2_full", 32'({full, words_available}), 32'h600);
        check("t2_no_overflow_yet", 32'(overflow), 32'd0);
        word_in = 16'hDEAD; tick();
        check("t2_overflow", 32'(overflow), 32'd1);
        check("t2_count_stays", 32'(words_available), 32'd512);

        // 6a: clear_flags beats a same-cycle overflow
        clear_flags = 1'b1; tick();
        clear_flags = 1'b0; word_valid = 1'b0;
        check("t6_clear_priority", 32'(overflow), 32'd0);
        check("t6_count_full", 32'(words_available), 32'd512);

        gaps = 0;
        sample_en = 1'b1;
        for (int k = 0; k < 513; k++) begin
            acc = 16'h0;
            for (int s = 0; s < 8; s++) begin
                tick();
                if (!sample_valid) gaps++;
                acc = {acc[13:0], sample_out};
            end
            check("t2_data_intact", 32'(acc), 32'(pat(k)));
        end
        sample_en = 1'b0;
        $display("t2 drained 513 words gaps=%0d avail=%0d", gaps, words_available);
        check("t2_no_gaps", 32'(gaps), 32'd0);
        check("t2_drained", 32'({have_data, words_available}), 32'd0);
        check("t2_no_underflow", 32'(underflow), 32'd0);

        // 6b: write and holder load on the same edge at count 5
        reset = 1'b1; tick(); reset = 1'b0;
        word_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            word_in = 16'(k);
            tick();
        end
        word_valid = 1'b0;
        check("t6_count_5", 32'(words_available), 32'd5);
        sample_en = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        check("t6_count_5_mid_word", 32'(words_available), 32'd5);
        word_valid = 1'b1; word_in = 16'h1234; tick();
        word_valid = 1'b0; sample_en = 1'b0;
        $display("t6 simultaneous write+load avail=%0d valid=%0d", words_available, sample_valid);
        check("t6_count_unchanged", 32'(words_available), 32'd5);
        check("t6_last_slice_valid", 32'(sample_valid), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
